// File: rtl/ifu_fetch.sv
// ============================================================================
// ifu_fetch : instruction fetch unit, valid/ready imem port, fault + flush
// Rev 1.0
// ============================================================================
`default_nettype none

module ifu_fetch #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  input  logic        flush,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_fault,
  output logic [1:0]  fault_cause,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  output logic        imem_resp_ready,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err
);

  localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS   = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic        drain_q, drain_d;
  logic [15:0] timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      drain_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      drain_q <= drain_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cause_d = cause_q;
    drain_d = drain_q;
    timer_d = timer_q;

    // A stale response can only arrive outside WAIT; the first one retires the drain.
    if (drain_q && (state_q != S_WAIT) && imem_resp_valid) begin
      drain_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (fetch_req && !drain_q) begin
          if (pc[1:0] != 2'b00) begin
            state_d = S_HOLD;
            inst_d  = NOP_INST;
            fault_d = 1'b1;
            cause_d = CAUSE_ALIGN;
          end else begin
            state_d = S_REQ;
            addr_d  = pc;
          end
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_d = S_HOLD;
          inst_d  = imem_resp_err ? NOP_INST : imem_resp_data;
          fault_d = imem_resp_err;
          cause_d = imem_resp_err ? CAUSE_BUS : CAUSE_NONE;
        end else if (timer_q == TIMER_MAX) begin
          state_d = S_HOLD;
          inst_d  = NOP_INST;
          fault_d = 1'b1;
          cause_d = CAUSE_TMO;
          drain_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything; an accepted-but-unanswered request must be drained.
    if (flush) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      inst_d  = inst_q;
      fault_d = fault_q;
      cause_d = cause_q;
      timer_d = timer_q;
      if ((state_q == S_REQ && imem_req_ready) ||
          (state_q == S_WAIT && !imem_resp_valid)) begin
        drain_d = 1'b1;
      end
    end
  end

  assign inst_valid      = (state_q == S_HOLD);
  assign inst            = inst_q;
  assign inst_fault      = fault_q;
  assign fault_cause     = cause_q;
  assign imem_req_valid  = (state_q == S_REQ);
  assign imem_req_addr   = {addr_q[31:2], 2'b00};
  assign imem_resp_ready = (state_q == S_WAIT) || drain_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// tb_ifu_fetch : directed self-checking bench for ifu_fetch (TIMEOUT=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_req;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_fault;
  logic [1:0]  fault_cause;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_accept = 0;
  logic stale_seen = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch #(.TIMEOUT(8), .NOP_INST(32'h00000013)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .fetch_req       (fetch_req),
    .flush           (flush),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_fault      (inst_fault),
    .fault_cause     (fault_cause),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err)
  );

  always @(posedge clk) if (imem_req_valid && imem_req_ready) n_accept <= n_accept + 1;
  always @(negedge clk)
    if (inst_valid && (inst == 32'hDEADBEEF || inst == 32'hCAFEBABE)) stale_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},   32'(inst_valid), 32'd0);
    check({tag, ".inst"},    inst, 32'd0);
    check({tag, ".fault"},   32'(inst_fault), 32'd0);
    check({tag, ".cause"},   32'(fault_cause), 32'd0);
    check({tag, ".reqv"},    32'(imem_req_valid), 32'd0);
    check({tag, ".respr"},   32'(imem_resp_ready), 32'd0);
    check({tag, ".addr"},    imem_req_addr, 32'd0);
  endtask

  int acc0;

  initial begin
    reset = 1'b1; pc = '0; fetch_req = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;

    // normal fetch
    pc = 32'h80000000; fetch_req = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("nrm.c1.reqv", 32'(imem_req_valid), 32'd1);
    check("nrm.c1.addr", imem_req_addr, 32'h80000000);
    tick();
    imem_req_ready = 1'b0;
    check("nrm.c2.reqv", 32'(imem_req_valid), 32'd0);
    check("nrm.c2.respr", 32'(imem_resp_ready), 32'd1);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00100093;
    tick();
    imem_resp_valid = 1'b0;
    check("nrm.c3.valid", 32'(inst_valid), 32'd1);
    check("nrm.c3.inst", inst, 32'h00100093);
    check("nrm.c3.fault", 32'(inst_fault), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nrm.hold.valid", 32'(inst_valid), 32'd1);
      check("nrm.hold.inst", inst, 32'h00100093);
    end
    consume();
    check("nrm.drop.valid", 32'(inst_valid), 32'd0);
    check("nrm.drop.inst", inst, 32'h00100093);

    // backpressure on the request
    acc0 = n_accept;
    pc = 32'h80000004; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("bp.reqv", 32'(imem_req_valid), 32'd1);
      check("bp.addr", imem_req_addr, 32'h80000004);
      tick();
    end
    check("bp.c5.reqv", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("bp.c6.reqv", 32'(imem_req_valid), 32'd0);
    check("bp.c6.valid", 32'(inst_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00200113;
    tick();
    imem_resp_valid = 1'b0;
    check("bp.c7.valid", 32'(inst_valid), 32'd1);
    check("bp.c7.inst", inst, 32'h00200113);
    check("bp.accepts", 32'(n_accept - acc0), 32'd1);
    consume();

    // misaligned pc
    acc0 = n_accept;
    pc = 32'h80000002; fetch_req = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("mis.reqv", 32'(imem_req_valid), 32'd0);
    check("mis.valid", 32'(inst_valid), 32'd1);
    check("mis.inst", inst, 32'h00000013);
    check("mis.fault", 32'(inst_fault), 32'd1);
    check("mis.cause", 32'(fault_cause), 32'd1);
    consume();
    imem_req_ready = 1'b0;
    check("mis.accepts", 32'(n_accept - acc0), 32'd0);

    // bus error
    pc = 32'h80000008; fetch_req = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_err = 1'b1; imem_resp_data = 32'h12345678;
    tick();
    imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    check("berr.valid", 32'(inst_valid), 32'd1);
    check("berr.inst", inst, 32'h00000013);
    check("berr.fault", 32'(inst_fault), 32'd1);
    check("berr.cause", 32'(fault_cause), 32'd2);
    consume();

    // timeout, then late response drained before next fetch
    pc = 32'h8000000C; fetch_req = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("tmo.wait.valid", 32'(inst_valid), 32'd0);
      check("tmo.wait.respr", 32'(imem_resp_ready), 32'd1);
      tick();
    end
    check("tmo.valid", 32'(inst_valid), 32'd1);
    check("tmo.inst", inst, 32'h00000013);
    check("tmo.fault", 32'(inst_fault), 32'd1);
    check("tmo.cause", 32'(fault_cause), 32'd3);
    check("tmo.drain.respr", 32'(imem_resp_ready), 32'd1);
    consume();
    pc = 32'h80000020; fetch_req = 1'b1;
    tick();
    check("tmo.blk1.reqv", 32'(imem_req_valid), 32'd0);
    tick();
    check("tmo.blk2.reqv", 32'(imem_req_valid), 32'd0);
    check("tmo.late.respr", 32'(imem_resp_ready), 32'd1);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFEBABE;
    tick();
    imem_resp_valid = 1'b0;
    check("tmo.drained.reqv", 32'(imem_req_valid), 32'd0);
    check("tmo.drained.respr", 32'(imem_resp_ready), 32'd0);
    tick();
    fetch_req = 1'b0;
    check("tmo.next.reqv", 32'(imem_req_valid), 32'd1);
    check("tmo.next.addr", imem_req_addr, 32'h80000020);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00300193;
    tick();
    imem_resp_valid = 1'b0;
    check("tmo.next.inst", inst, 32'h00300193);
    check("tmo.next.cause", 32'(fault_cause), 32'd0);
    consume();

    // flush while waiting for a response
    pc = 32'h80000030; fetch_req = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl.valid", 32'(inst_valid), 32'd0);
    check("fl.reqv", 32'(imem_req_valid), 32'd0);
    check("fl.respr", 32'(imem_resp_ready), 32'd1);
    pc = 32'h80000010; fetch_req = 1'b1;
    tick();
    check("fl.blk.reqv", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
    tick();
    imem_resp_valid = 1'b0;
    check("fl.drained.reqv", 32'(imem_req_valid), 32'd0);
    tick();
    fetch_req = 1'b0;
    check("fl.next.reqv", 32'(imem_req_valid), 32'd1);
    check("fl.next.addr", imem_req_addr, 32'h80000010);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00400213;
    tick();
    imem_resp_valid = 1'b0;
    check("fl.next.valid", 32'(inst_valid), 32'd1);
    check("fl.next.inst", inst, 32'h00400213);
    consume();

    // reset while waiting
    pc = 32'h80000040; fetch_req = 1'b1; imem_req_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    check("rst.inwait.respr", 32'(imem_resp_ready), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rst.mid");
    pc = 32'h80000050; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("rst.nodrain.reqv", 32'(imem_req_valid), 32'd1);
    check("rst.nodrain.addr", imem_req_addr, 32'h80000050);

    check("stale_never_presented", 32'(stale_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
